// File: rtl/command_receiver.sv
// UART (8N1, LSB first) receiver plus two-byte command parser: a HEADER byte followed
// by a data byte produces a one-cycle write of that data byte.
//
// state      | meaning
// RX_IDLE    | line idle, waiting for a falling edge on rx_s
// RX_START   | half-bit wait to the middle of the start bit
// RX_DATA    | sampling 8 data bits, one per bit period
// RX_STOP    | waiting to sample the middle of the stop bit
// RX_RECOVER | stop bit was low, waiting for the line to return high
// P_WAIT_HDR | parser expects a HEADER byte
// P_WAIT_DAT | parser expects the data byte of a frame
module command_receiver #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hC3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       write,
  output logic [7:0] write_register,
  output logic       frame_error,
  output logic       busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;
  typedef enum logic {P_WAIT_HDR, P_WAIT_DAT} p_state_t;

  rx_state_t     rx_state, rx_next;
  p_state_t      p_state, p_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic          tick, shift_en, byte_ok, stop_bad, wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:    if (!rx_s) rx_next = RX_START;
      RX_START:   if (tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:    if (tick && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:    if (tick) rx_next = rx_s ? RX_IDLE : RX_RECOVER;
      RX_RECOVER: if (rx_s) rx_next = RX_IDLE;
      default:    rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    shift_en = (rx_state == RX_DATA) && tick;
    byte_ok  = (rx_state == RX_STOP) && tick && rx_s;
    stop_bad = (rx_state == RX_STOP) && tick && !rx_s;
  end

  // Counter reloads on every state change and between data bits, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= byte_ok;
      frame_error <= stop_bad;
      if (rx_next != rx_state)
        cnt <= (rx_next == RX_START) ? HALF_LD : FULL_LD;
      else if (shift_en)
        cnt <= FULL_LD;
      else if (!tick)
        cnt <= cnt - CW'(1);
      if (rx_state == RX_IDLE && !rx_s)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)
        shreg <= {rx_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) p_state <= P_WAIT_HDR;
    else       p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    case (p_state)
      P_WAIT_HDR: if (byte_valid && shreg == HEADER) p_next = P_WAIT_DAT;
      P_WAIT_DAT: if (byte_valid || frame_error) p_next = P_WAIT_HDR;
      default:    p_next = P_WAIT_HDR;
    endcase
  end

  always_comb begin
    wr_en = (p_state == P_WAIT_DAT) && byte_valid;
  end

  // byte_valid keeps busy high across the hand-off from receiver to parser.
  always_ff @(posedge clk) begin
    if (reset) begin
      write          <= 1'b0;
      write_register <= 8'h00;
      busy           <= 1'b0;
    end else begin
      write <= wr_en;
      if (wr_en) write_register <= shreg;
      busy <= (rx_state != RX_IDLE) || (p_state == P_WAIT_DAT) || byte_valid;
    end
  end

endmodule
